// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modular-exponentiation host front end:
//   - rsa_state_t : controller state encoding (IDLE, RUN, RELEASE, STREAM)
//   - SEL_X/E/N   : operand select codes carried on wr_sel
//   - DEF_WIDTH / DEF_WORD : default operand and host word widths
//   - ptr_bits()  : width of a word pointer for a given words-per-operand
// ---------------------------------------------------------------------------
package rsa_pkg;

    localparam int DEF_WIDTH = 4096;
    localparam int DEF_WORD  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_STREAM  = 2'd3
    } rsa_state_t;

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_E = 2'd1;
    localparam logic [1:0] SEL_N = 2'd2;

    // A single-word operand still needs a 1-bit pointer to keep vectors legal.
    function automatic int ptr_bits(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/rsa_word_serializer.sv
// ---------------------------------------------------------------------------
// rsa_word_serializer
// Holds the WIDTH-bit engine result and streams it to the host one WORD at a
// time, least significant word first.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_load       capture i_result into the result register
//   i_result     WIDTH-bit engine result
//   i_start      begin streaming from word 0 (rd_valid rises next cycle)
//   i_ready      host accepts the current word
//   o_valid      current word valid
//   o_data       current word (result[rp*WORD +: WORD])
//   o_last       current word is the final one
//   o_done       final handshake happens this cycle
//
// Handshake: a word transfers on a cycle where o_valid and i_ready are both
// high. While o_valid is high and i_ready is low, o_valid, o_data and o_last
// hold their values; o_valid never drops without a transfer.
// ---------------------------------------------------------------------------
module rsa_word_serializer
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORD  = DEF_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_start,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WORD-1:0]  o_data,
    output logic             o_last,
    output logic             o_done
);

    localparam int NW  = WIDTH / WORD;
    localparam int RPW = ptr_bits(NW);
    localparam logic [RPW-1:0] RP_LAST = RPW'(NW - 1);

    logic [WIDTH-1:0] r_result;
    logic [RPW-1:0]   r_rp;
    logic             r_valid;

    logic             w_hs;
    logic             w_at_last;
    logic [WORD-1:0]  w_data;

    assign w_at_last = (r_rp == RP_LAST);
    assign w_hs      = r_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_rp     <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_load) begin
                r_result <= i_result;
            end
            if (i_start) begin
                r_rp    <= '0;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                if (w_at_last) begin
                    r_rp    <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_rp <= r_rp + RPW'(1);
                end
            end
        end
    end

    // Word select mux driven only by registers, so o_data is glitch-free
    // relative to the host and stable while i_ready is low.
    always_comb begin
        w_data = '0;
        for (int w = 0; w < NW; w++) begin
            if (r_rp == w[RPW-1:0]) begin
                w_data = r_result[w*WORD +: WORD];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = w_data;
    assign o_last  = r_valid && w_at_last;
    assign o_done  = w_hs && w_at_last;

endmodule

// File: rtl/rsa_io_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_io_ctrl
// Host-side front end for the mont_lad modular-exponentiation engine.
// Operands X, E and N are loaded one WORD at a time into WIDTH-bit holding
// registers; a start request launches the engine through a go/done handshake,
// and the result is streamed back with valid/ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_data host write port (sel 0=X, 1=E, 2=N, 3=ignored)
//   start               request an exponentiation (IDLE only)
//   busy                controller not in IDLE
//   err                 one-cycle pulse: start rejected (operand not full)
//   X, E, N             operands to engine
//   go / done_in        engine handshake
//   O_in                engine result
//   rd_valid/rd_ready/rd_data/rd_last  result stream to host
//   dbg_state           current controller state
//
// WIDTH must be an integer multiple of WORD.
// ---------------------------------------------------------------------------
module rsa_io_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORD  = DEF_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [WORD-1:0]  wr_data,
    input  logic             start,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] N,
    output logic             go,
    input  logic             done_in,
    input  logic [WIDTH-1:0] O_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WORD-1:0]  rd_data,
    output logic             rd_last,
    output rsa_state_t       dbg_state
);

    localparam int NW = WIDTH / WORD;
    localparam int PW = ptr_bits(NW);
    localparam logic [PW-1:0] P_LAST = PW'(NW - 1);

    rsa_state_t       r_state;
    logic             r_go;
    logic             r_err;
    logic [WIDTH-1:0] r_op   [3];
    logic [PW-1:0]    r_ptr  [3];
    logic [2:0]       r_full;

    logic             w_ser_load;
    logic             w_ser_start;
    logic             w_ser_done;

    // Result is captured on the first done_in cycle seen in RUN; streaming
    // begins once the engine has dropped done after go fell.
    assign w_ser_load  = (r_state == ST_RUN) && done_in;
    assign w_ser_start = (r_state == ST_RELEASE) && !done_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_go    <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= '0;
            for (int s = 0; s < 3; s++) begin
                r_op[s]  <= '0;
                r_ptr[s] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_en && (wr_sel != 2'd3)) begin
                        for (int s = 0; s < 3; s++) begin
                            if (wr_sel == s[1:0]) begin
                                for (int w = 0; w < NW; w++) begin
                                    if (r_ptr[s] == w[PW-1:0]) begin
                                        r_op[s][w*WORD +: WORD] <= wr_data;
                                    end
                                end
                                // Wrapping marks the operand complete; later
                                // writes overwrite from word 0 and keep full.
                                if (r_ptr[s] == P_LAST) begin
                                    r_ptr[s]  <= '0;
                                    r_full[s] <= 1'b1;
                                end else begin
                                    r_ptr[s] <= r_ptr[s] + PW'(1);
                                end
                            end
                        end
                    end
                    // Full flags are sampled before any same-cycle write.
                    if (start) begin
                        if (&r_full) begin
                            r_state <= ST_RUN;
                            r_go    <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (done_in) begin
                        r_state <= ST_RELEASE;
                        r_go    <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (!done_in) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Operands are kept, but the host must reload all three
                    // before the next start since the full flags are cleared.
                    if (w_ser_done) begin
                        r_state <= ST_IDLE;
                        r_full  <= '0;
                        for (int s = 0; s < 3; s++) begin
                            r_ptr[s] <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_go    <= 1'b0;
                end
            endcase
        end
    end

    rsa_word_serializer #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_ser_load),
        .i_result (O_in),
        .i_start  (w_ser_start),
        .i_ready  (rd_ready),
        .o_valid  (rd_valid),
        .o_data   (rd_data),
        .o_last   (rd_last),
        .o_done   (w_ser_done)
    );

    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;
    assign go        = r_go;
    assign X         = r_op[0];
    assign E         = r_op[1];
    assign N         = r_op[2];
    assign dbg_state = r_state;

endmodule

// File: doc/rsa_io_ctrl.md
Name: rsa_io_ctrl

Overview:
- Host-side front end for the modular-exponentiation engine (mont_lad).
- Loads X, E and N one word at a time over a narrow write port into WIDTH-bit holding registers, then drives the engine's go/done handshake.
- Captures the WIDTH-bit result O and streams it back to the host word by word using valid/ready.
- Sits directly between the host bus adapter and mont_lad.

Parameters:
- WIDTH, 4096, operand/result width in bits; must equal the engine's width.
- WORD, 32, host word width in bits; WIDTH must be an integer multiple of WORD.
- NW (localparam), WIDTH/WORD, words per operand.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe; one word per cycle
- wr_sel  in  2  operand select: 0=X, 1=E, 2=N, 3=ignored
- wr_data  in  WORD  write word
- start  in  1  single-cycle request to run an exponentiation
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse when start is rejected
- X  out  WIDTH  base, to engine
- E  out  WIDTH  exponent, to engine
- N  out  WIDTH  modulus, to engine
- go  out  1  engine go
- done_in  in  1  engine done
- O_in  in  WIDTH  engine result
- rd_valid  out  1  result word valid
- rd_ready  in  1  host accepts result word
- rd_data  out  WORD  result word
- rd_last  out  1  high with the final result word

Behaviour:
- Reset values: all outputs 0; X, E, N and the result register 0; all pointers and flags 0; state IDLE. Reset mid-operation aborts immediately, go drops, and the engine returns to its wait state because go is low.
- Loading (IDLE only):
  - Each operand has its own log2(NW)-bit write pointer.
  - wr_en with wr_sel=s writes wr_data into word ptr[s] of operand s (bits ptr*WORD +: WORD); ptr[s] then increments.
  - Word 0 is least significant.
  - When ptr[s] wraps from NW-1 to 0, set full[s]=1. Further writes overwrite from word 0 and full[s] stays set.
  - wr_sel=3 is ignored. wr_en outside IDLE is ignored, with no register or pointer change.
- start handling:
  - start in IDLE with full[X], full[E] and full[N] all set: go to RUN.
  - start in IDLE with any full flag clear: stay in IDLE and pulse err next cycle.
  - start outside IDLE is ignored (no err).
  - If wr_en and start arrive in the same IDLE cycle, the write completes first and full flags are evaluated before that write.
- State machine:
  - IDLE -> RUN: on an accepted start; go=1 from the next cycle.
  - RUN: go held at 1. On the first cycle with done_in=1, latch O_in into the result register and move to RELEASE.
  - RELEASE: go=0; wait for done_in=0. That state may last a single cycle, since the engine clears done once go falls.
  - RELEASE -> STREAM: result word pointer rp=0.
  - STREAM: rd_valid=1 and rd_data = result[rp*WORD +: WORD]; rd_last=1 when rp=NW-1.
    - On rd_valid&rd_ready, rp increments.
    - On the last handshake: go to IDLE, clear rp, clear all write pointers and full flags.
    - X, E and N retain their values, so the host must reload all three before the next start.
    - rd_valid, rd_data and rd_last stay stable while rd_ready is low.
- Latency: accepted start -> go high 1 cycle later. done_in rise -> go low 1 cycle later. rd_valid rises 1 cycle after RELEASE sees done_in=0.
- X, E and N are stable for the whole time go=1, because writes are blocked.
- done_in=1 seen in IDLE or STREAM is ignored.

Decomposition:
- Shared package rsa_pkg: state encoding (IDLE, RUN, RELEASE, STREAM), operand select constants SEL_X=0, SEL_E=1, SEL_N=2, and the default WIDTH/WORD values.
- One natural sub-module: rsa_word_serializer, holding the result register, rp and the valid/ready/last logic, instantiated once.
- Word loading stays inline.

Test Plan (WIDTH=64, WORD=16, NW=4, behavioural engine model computing X^E mod N after 20 cycles):
- Load X=5, E=3, N=13 (words 0x0005/0x0003/0x000D, then three 0x0000 each), start -> go high next cycle; after the model asserts done, go drops; stream gives 0x0008, 0, 0, 0 with rd_last on word 3.
- Load X and E fully, N with only 2 words, start -> err pulse, busy stays 0, go stays 0.
- Stream with rd_ready toggling 1,0,0,1,... -> each word is held stable while rd_ready=0; exactly 4 handshakes; IDLE afterwards.
- wr_en during RUN with wr_sel=0, wr_data=0xFFFF -> X unchanged (observable on the X port); second start during RUN ignored, no err.
- Assert rst while in RUN (go=1) -> go, busy, rd_valid and err all 0 in the same cycle; X, E, N and full flags cleared; a fresh load of X=2, E=10, N=1000 then gives result 24 (0x0018).
- Write 5 words to X -> word 0 overwritten by the 5th write; full[X] stays set; X value matches the last 4 writes in wrap order.
